// File: rtl/ex_mem_req_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_req_if
// Brief    : SRAM-like data-port bundle between the EX stage and data memory.
// Revision : 1.0
// ============================================================================
interface ex_mem_req_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_req
// Brief    : EX-stage load/store request issue, ALE detection and discard of
//            responses belonging to flushed-but-accepted requests.
// Revision : 1.0
// ============================================================================
module ex_mem_req #(
  parameter int DISC_W = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        EX_valid,
  input  wire logic [7:0]  mem_ctrl,
  input  wire logic        ex_exc,
  input  wire logic        flush,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] rkd_value,
  input  wire logic        MEM_allow_in,
  ex_mem_req_if.master     data_sram,
  output logic             data_ok_to_mem,
  output logic             ale,
  output logic             wait_data_ok,
  output logic             EX_ready_go
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DISC_W-1:0] disc_cnt;
  logic              kill;

  logic              wr_lat;
  logic [1:0]        size_lat;
  logic [3:0]        wstrb_lat;
  logic [31:0]       addr_lat;
  logic [31:0]       wdata_lat;

  logic              wr_now;
  logic [1:0]        size_now;
  logic [3:0]        wstrb_now;
  logic [31:0]       wdata_now;

  wire logic st_w   = mem_ctrl[7];
  wire logic st_h   = mem_ctrl[6];
  wire logic st_b   = mem_ctrl[5];
  wire logic is_word = mem_ctrl[7] | mem_ctrl[4];
  wire logic is_half = mem_ctrl[6] | mem_ctrl[1] | mem_ctrl[0];
  wire logic mem_op  = |mem_ctrl;

  wire logic ale_raw   = EX_valid & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  wire logic disc_zero = (disc_cnt == '0);
  wire logic issue     = EX_valid & mem_op & ~ex_exc & ~ale_raw & ~flush & disc_zero;
  wire logic req_raw   = ((state == S_IDLE) & issue) | (state == S_REQ);
  wire logic accept    = req_raw & data_sram.addr_ok;
  wire logic killed    = kill | flush;

  wire logic disc_inc = ((state == S_REQ) & accept & killed) | ((state == S_DONE) & flush);
  wire logic disc_dec = data_sram.data_ok & ~disc_zero;

  always_comb begin
    wr_now    = st_w | st_h | st_b;
    size_now  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    wstrb_now = 4'b0000;
    wdata_now = rkd_value;
    if (st_b) begin
      wstrb_now = 4'b0001 << addr[1:0];
      wdata_now = {4{rkd_value[7:0]}};
    end else if (st_h) begin
      wstrb_now = addr[1] ? 4'b1100 : 4'b0011;
      wdata_now = {2{rkd_value[15:0]}};
    end else if (st_w) begin
      wstrb_now = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_raw)
                state_nxt = data_sram.addr_ok ? (MEM_allow_in ? S_IDLE : S_DONE) : S_REQ;
      S_REQ:  if (data_sram.addr_ok)
                state_nxt = (killed | MEM_allow_in) ? S_IDLE : S_DONE;
      S_DONE: if (flush | MEM_allow_in)
                state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are frozen on the first req cycle so a held request stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill      <= 1'b0;
      wr_lat    <= 1'b0;
      size_lat  <= 2'd0;
      wstrb_lat <= 4'd0;
      addr_lat  <= 32'd0;
      wdata_lat <= 32'd0;
      disc_cnt  <= '0;
    end else begin
      if (state == S_REQ) kill <= accept ? 1'b0 : (kill | flush);
      else                kill <= 1'b0;
      if ((state == S_IDLE) && req_raw) begin
        wr_lat    <= wr_now;
        size_lat  <= size_now;
        wstrb_lat <= wstrb_now;
        addr_lat  <= addr;
        wdata_lat <= wdata_now;
      end
      if (disc_inc && !disc_dec && (disc_cnt != '1))
        disc_cnt <= disc_cnt + 1'b1;
      else if (disc_dec && !disc_inc)
        disc_cnt <= disc_cnt - 1'b1;
    end
  end

  always_comb begin
    data_sram.req   = 1'b0;
    data_sram.wr    = 1'b0;
    data_sram.size  = 2'd0;
    data_sram.wstrb = 4'd0;
    data_sram.addr  = 32'd0;
    data_sram.wdata = 32'd0;
    data_ok_to_mem  = 1'b0;
    ale             = 1'b0;
    wait_data_ok    = 1'b0;
    EX_ready_go     = ~EX_valid | ~mem_op | ex_exc | ale_raw | (state == S_DONE)
                    | (req_raw & data_sram.addr_ok & ~kill & ~flush & reset);
    if (reset) begin
      data_sram.req   = req_raw;
      data_sram.wr    = (state == S_IDLE) ? wr_now    : wr_lat;
      data_sram.size  = (state == S_IDLE) ? size_now  : size_lat;
      data_sram.wstrb = (state == S_IDLE) ? wstrb_now : wstrb_lat;
      data_sram.addr  = (state == S_IDLE) ? addr      : addr_lat;
      data_sram.wdata = (state == S_IDLE) ? wdata_now : wdata_lat;
      data_ok_to_mem  = data_sram.data_ok & disc_zero;
      ale             = ale_raw;
      wait_data_ok    = EX_valid & mem_op & ~ex_exc & ~ale_raw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_req
// Brief    : Directed scoreboard bench for ex_mem_req.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_req;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_valid;
  logic [7:0]  mem_ctrl;
  logic        ex_exc;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] rkd_value;
  logic        MEM_allow_in;
  logic        data_ok_to_mem;
  logic        ale;
  logic        wait_data_ok;
  logic        EX_ready_go;

  int   checks   = 0;
  int   failures = 0;
  req_t exp_q[$];

  ex_mem_req_if bus ();

  ex_mem_req #(.DISC_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .EX_valid       (EX_valid),
    .mem_ctrl       (mem_ctrl),
    .ex_exc         (ex_exc),
    .flush          (flush),
    .addr           (addr),
    .rkd_value      (rkd_value),
    .MEM_allow_in   (MEM_allow_in),
    .data_sram      (bus),
    .data_ok_to_mem (data_ok_to_mem),
    .ale            (ale),
    .wait_data_ok   (wait_data_ok),
    .EX_ready_go    (EX_ready_go)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                      input logic [31:0] a, input logic [31:0] wd);
    req_t e;
    e.wr = wr; e.size = size; e.wstrb = wstrb; e.addr = a; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  // Every cycle the bus shows req, its fields must match the oldest expected request.
  always @(negedge clk) begin
    if (reset && bus.req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        chk("req_wr",    {31'd0, bus.wr},    {31'd0, exp_q[0].wr});
        chk("req_size",  {30'd0, bus.size},  {30'd0, exp_q[0].size});
        chk("req_wstrb", {28'd0, bus.wstrb}, {28'd0, exp_q[0].wstrb});
        chk("req_addr",  bus.addr,           exp_q[0].addr);
        if (exp_q[0].wr) chk("req_wdata", bus.wdata, exp_q[0].wdata);
        if (bus.addr_ok) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; EX_valid = 1'b1; mem_ctrl = 8'h10; ex_exc = 1'b0; flush = 1'b0;
    addr = 32'h1000; rkd_value = 32'd0; MEM_allow_in = 1'b1;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1;

    @(negedge clk);
    chk("rst_req",   {31'd0, bus.req},        32'd0);
    chk("rst_dok",   {31'd0, data_ok_to_mem}, 32'd0);
    chk("rst_wait",  {31'd0, wait_data_ok},   32'd0);
    chk("rst_ready", {31'd0, EX_ready_go},    32'd0);
    EX_valid = 1'b0; mem_ctrl = 8'h00; bus.data_ok = 1'b0;
    @(negedge clk);
    chk("rst_ready_idle", {31'd0, EX_ready_go}, 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // ld_w accepted immediately with MEM ready
    push(1'b0, 2'd2, 4'h0, 32'h1000, 32'd0);
    EX_valid = 1'b1; mem_ctrl = 8'h10; addr = 32'h1000; bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("ldw_req",   {31'd0, bus.req},      32'd1);
    chk("ldw_ready", {31'd0, EX_ready_go},  32'd1);
    chk("ldw_wait",  {31'd0, wait_data_ok}, 32'd1);
    chk("ldw_ale",   {31'd0, ale},          32'd0);
    tick();
    EX_valid = 1'b0; bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("ldw_req_drop", {31'd0, bus.req}, 32'd0);
    tick();
    bus.data_ok = 1'b1;
    @(negedge clk);
    chk("ldw_dok", {31'd0, data_ok_to_mem}, 32'd1);
    tick();
    bus.data_ok = 1'b0;

    // st_b held for 4 cycles while inputs change underneath
    push(1'b1, 2'd0, 4'b1000, 32'h1003, 32'hA5A5A5A5);
    EX_valid = 1'b1; mem_ctrl = 8'h20; addr = 32'h1003; rkd_value = 32'h000000A5;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin addr = 32'h5554; rkd_value = 32'h00000011; end
      if (i == 3) bus.addr_ok = 1'b1;
      @(negedge clk);
      chk("stb_req",   {31'd0, bus.req},     32'd1);
      chk("stb_ready", {31'd0, EX_ready_go}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    EX_valid = 1'b0; bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("stb_req_drop", {31'd0, bus.req}, 32'd0);
    tick();
    bus.data_ok = 1'b1;
    @(negedge clk);
    chk("stb_dok", {31'd0, data_ok_to_mem}, 32'd1);
    tick();
    bus.data_ok = 1'b0;

    // st_h accepted while MEM is stalled: waits in DONE
    push(1'b1, 2'd1, 4'b1100, 32'h2002, 32'hBEEFBEEF);
    EX_valid = 1'b1; mem_ctrl = 8'h40; addr = 32'h2002; rkd_value = 32'h1234BEEF;
    bus.addr_ok = 1'b1; MEM_allow_in = 1'b0;
    @(negedge clk);
    chk("sth_ready", {31'd0, EX_ready_go}, 32'd1);
    tick();
    bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("done_req",   {31'd0, bus.req},     32'd0);
    chk("done_ready", {31'd0, EX_ready_go}, 32'd1);
    tick();
    MEM_allow_in = 1'b1;
    @(negedge clk);
    chk("done_ready2", {31'd0, EX_ready_go}, 32'd1);
    tick();
    EX_valid = 1'b0; bus.data_ok = 1'b1;
    @(negedge clk);
    chk("sth_dok", {31'd0, data_ok_to_mem}, 32'd1);
    tick();
    bus.data_ok = 1'b0;

    // misaligned half load and word store
    EX_valid = 1'b1; mem_ctrl = 8'h02; addr = 32'h2001;
    @(negedge clk);
    chk("ldh_ale",   {31'd0, ale},          32'd1);
    chk("ldh_req",   {31'd0, bus.req},      32'd0);
    chk("ldh_ready", {31'd0, EX_ready_go},  32'd1);
    chk("ldh_wait",  {31'd0, wait_data_ok}, 32'd0);
    tick();
    mem_ctrl = 8'h80; addr = 32'h2002;
    @(negedge clk);
    chk("stw_ale", {31'd0, ale},     32'd1);
    chk("stw_req", {31'd0, bus.req}, 32'd0);
    tick();

    // st_w flushed while waiting in REQ; its response must be swallowed
    push(1'b1, 2'd2, 4'hF, 32'h3000, 32'hDEADBEEF);
    addr = 32'h3000; rkd_value = 32'hDEADBEEF;
    @(negedge clk);
    chk("fl_req0", {31'd0, bus.req}, 32'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_req1",   {31'd0, bus.req},     32'd1);
    chk("fl_ready1", {31'd0, EX_ready_go}, 32'd0);
    tick();
    flush = 1'b0; EX_valid = 1'b0;
    @(negedge clk);
    chk("fl_req2", {31'd0, bus.req}, 32'd1);
    tick();
    bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("fl_req3", {31'd0, bus.req}, 32'd1);
    tick();
    bus.addr_ok = 1'b0;

    // ld_b blocked until the stale response drains
    push(1'b0, 2'd0, 4'h0, 32'h4001, 32'd0);
    EX_valid = 1'b1; mem_ctrl = 8'h08; addr = 32'h4001;
    @(negedge clk);
    chk("blk_req0",   {31'd0, bus.req},     32'd0);
    chk("blk_ready0", {31'd0, EX_ready_go}, 32'd0);
    tick();
    @(negedge clk);
    chk("blk_req1", {31'd0, bus.req}, 32'd0);
    tick();
    bus.data_ok = 1'b1;
    @(negedge clk);
    chk("stale_dok", {31'd0, data_ok_to_mem}, 32'd0);
    chk("blk_req2",  {31'd0, bus.req},        32'd0);
    tick();
    bus.data_ok = 1'b0; bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("ldb_req",   {31'd0, bus.req},     32'd1);
    chk("ldb_ready", {31'd0, EX_ready_go}, 32'd1);
    tick();
    EX_valid = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
    @(negedge clk);
    chk("ldb_dok", {31'd0, data_ok_to_mem}, 32'd1);
    tick();
    bus.data_ok = 1'b0;

    // flush while parked in DONE leaves one response to discard; reset clears it
    push(1'b1, 2'd2, 4'hF, 32'h7000, 32'h01234567);
    EX_valid = 1'b1; mem_ctrl = 8'h80; addr = 32'h7000; rkd_value = 32'h01234567;
    bus.addr_ok = 1'b1; MEM_allow_in = 1'b0;
    tick();
    bus.addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("dfl_req", {31'd0, bus.req}, 32'd0);
    tick();
    flush = 1'b0; EX_valid = 1'b0; MEM_allow_in = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("dfl_rst_req", {31'd0, bus.req}, 32'd0);
    tick();
    reset = 1'b1; bus.data_ok = 1'b1;
    @(negedge clk);
    chk("dfl_rst_dok", {31'd0, data_ok_to_mem}, 32'd1);
    tick();
    bus.data_ok = 1'b0;

    // async reset while a request is held in REQ
    push(1'b0, 2'd2, 4'h0, 32'h6000, 32'd0);
    EX_valid = 1'b1; mem_ctrl = 8'h10; addr = 32'h6000;
    @(negedge clk);
    chk("rq_req0", {31'd0, bus.req}, 32'd1);
    tick();
    @(negedge clk);
    chk("rq_req1", {31'd0, bus.req}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("rq_rst_req", {31'd0, bus.req}, 32'd0);
    chk("rq_rst_wait", {31'd0, wait_data_ok}, 32'd0);
    void'(exp_q.pop_front());
    EX_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rq_after_req", {31'd0, bus.req}, 32'd0);
    tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
